// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, synchronous I-mem read issue, one-entry stall buffer and IF/ID register.
// Optional BRANCH_DELAY_SLOT_EN: redirect keeps the arriving delay-slot word instead of squashing it.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PC_en,
    input  logic        IFID_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_pc,
    output logic [31:0] IFID_instr,
    output logic        IFID_valid
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam logic SQUASH_ON_REDIRECT = 1'b0;
`else
    localparam logic SQUASH_ON_REDIRECT = 1'b1;
`endif

    logic [XLEN-1:0] r_pc;
    logic            r_f_valid;
    logic [XLEN-1:0] r_f_pc;
    logic            r_hold_valid;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] r_hold_instr;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_instr;
    logic            r_ifid_valid;

    logic            w_issue;
    logic [XLEN-1:0] w_fetch_addr;
    logic            w_arr_valid;
    logic [XLEN-1:0] w_arr_pc;
    logic [XLEN-1:0] w_arr_instr;
    logic            w_squash;

    // PC_en without IFID_en is a stall; a redirect always issues its target.
    assign w_issue      = redirect_valid | (PC_en & IFID_en);
    assign w_fetch_addr = redirect_valid ? redirect_pc : r_pc;
    assign imem_en      = w_issue;
    assign imem_addr    = w_fetch_addr;

    // The held word is older than the memory word, so it takes priority.
    assign w_arr_valid  = r_hold_valid | r_f_valid;
    assign w_arr_pc     = r_hold_valid ? r_hold_pc    : r_f_pc;
    assign w_arr_instr  = r_hold_valid ? r_hold_instr : imem_rdata;
    assign w_squash     = redirect_valid & SQUASH_ON_REDIRECT;

    // Fetch address and in-flight read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_f_valid <= 1'b0;
            r_f_pc    <= '0;
        end else begin
            r_f_valid <= w_issue;
            if (w_issue) begin
                r_pc   <= w_fetch_addr + PC_STEP;
                r_f_pc <= w_fetch_addr;
            end
        end
    end

    // IF/ID register and one-entry hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else if (w_squash) begin
            r_hold_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else if (IFID_en) begin
            r_hold_valid <= 1'b0;
            r_ifid_valid <= w_arr_valid;
            if (w_arr_valid) begin
                r_ifid_pc    <= w_arr_pc;
                r_ifid_instr <= w_arr_instr;
            end else begin
                r_ifid_instr <= '0;
            end
        end else if (!r_hold_valid && r_f_valid) begin
            r_hold_valid <= 1'b1;
            r_hold_pc    <= r_f_pc;
            r_hold_instr <= imem_rdata;
        end
    end

    assign IFID_pc    = r_ifid_pc;
    assign IFID_instr = r_ifid_instr;
    assign IFID_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: issued addresses are queued and matched against IF/ID as it loads.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        PC_en;
    logic        IFID_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IFID_pc;
    logic [31:0] IFID_instr;
    logic        IFID_valid;

    int unsigned n_chk;
    int unsigned n_err;
    logic [31:0] q[$];

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .PC_en         (PC_en),
        .IFID_en       (IFID_en),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .IFID_pc       (IFID_pc),
        .IFID_instr    (IFID_instr),
        .IFID_valid    (IFID_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory returning the address as data.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= imem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check the issue, clock, then score any IF/ID load.
    task automatic cyc(input logic pe, input logic ie, input logic rv, input logic [31:0] rpc,
                       input logic exp_en, input logic [31:0] exp_addr);
        logic [31:0] e;
        PC_en          = pe;
        IFID_en        = ie;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check("imem_en", 32'(imem_en), 32'(exp_en));
        if (exp_en) begin
            check("imem_addr", imem_addr, exp_addr);
`ifndef BRANCH_DELAY_SLOT_EN
            if (rv && q.size() > 0) void'(q.pop_back());
`endif
            q.push_back(exp_addr);
        end
        @(posedge clk);
        @(negedge clk);
        if (ie && IFID_valid) begin
            if (q.size() == 0) begin
                check("q_underflow", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                check("ifid_pc", IFID_pc, e);
                check("ifid_instr", IFID_instr, e);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        PC_en = 1'b0;
        IFID_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        #2;
        check("rst_ifid_pc", IFID_pc, 32'h0);
        check("rst_ifid_instr", IFID_instr, 32'h0);
        check("rst_ifid_valid", 32'(IFID_valid), 32'h0);
        check("rst_imem_en", 32'(imem_en), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Straight-line fetch from the reset vector.
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0000);
        check("first_bubble", 32'(IFID_valid), 32'h0);
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0004);
        check("first_valid", 32'(IFID_valid), 32'h1);
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0008);

        // Three-cycle stall with 0xBFC00008 in flight.
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("stall_frozen0", IFID_pc, 32'hBFC0_0004);
        cyc(1, 0, 0, 0, 0, 32'h0);
        check("stall_frozen1", IFID_pc, 32'hBFC0_0004);
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("stall_frozen2", IFID_pc, 32'hBFC0_0004);
        check("stall_valid", 32'(IFID_valid), 32'h1);
        cyc(1, 1, 0, 0, 1, 32'hBFC0_000C);
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0010);
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0014);
        check("branch_in_id", IFID_pc, 32'hBFC0_0010);

        // Redirect while the branch sits in ID.
        cyc(1, 1, 1, 32'h8000_0100, 1, 32'h8000_0100);
`ifndef BRANCH_DELAY_SLOT_EN
        check("redir_bubble_valid", 32'(IFID_valid), 32'h0);
        check("redir_bubble_instr", IFID_instr, 32'h0);
        check("redir_bubble_pc", IFID_pc, 32'hBFC0_0010);
`else
        check("delay_slot_pc", IFID_pc, 32'hBFC0_0014);
`endif
        cyc(1, 1, 0, 0, 1, 32'h8000_0104);
        check("target_in_id", IFID_pc, 32'h8000_0100);
        cyc(1, 1, 0, 0, 1, 32'h8000_0108);

        // Redirect to the top word, then wrap.
        cyc(1, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        cyc(1, 1, 0, 0, 1, 32'h0000_0000);
        cyc(1, 1, 0, 0, 1, 32'h0000_0004);
        check("wrap_in_id", IFID_pc, 32'h0000_0000);

        // Fill the hold buffer, then reset in the middle of the stall.
        cyc(1, 0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 0, 32'h0);
        check("held_pending", 32'(q.size()), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_ifid_pc", IFID_pc, 32'h0);
        check("midrst_ifid_instr", IFID_instr, 32'h0);
        check("midrst_ifid_valid", 32'(IFID_valid), 32'h0);
        check("midrst_imem_en", 32'(imem_en), 32'h0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0000);
        check("postrst_bubble", 32'(IFID_valid), 32'h0);
        cyc(1, 1, 0, 0, 1, 32'hBFC0_0004);
        check("postrst_pc", IFID_pc, 32'hBFC0_0000);
        cyc(0, 0, 0, 0, 0, 32'h0);

        check("q_leftover", 32'(q.size()), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, issues reads to the synchronous instruction memory, and owns the IF/ID pipeline register. It is the direct upstream neighbour of the hazard detection unit: it consumes that unit's `PC_en`/`IFID_en` stall controls and produces the `IFID_instr` from which `IFID_rs`/`IFID_rt` are taken. ID-resolved branch/jump redirects are applied here.

## Interface
- `RESET_PC`, 32'hBFC00000, first fetch address after reset.
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `PC_en`  in  1  from hazard unit; 0 = hold PC.
- `IFID_en`  in  1  from hazard unit; 0 = hold IF/ID register.
- `redirect_valid`  in  1  from ID; taken branch/jump this cycle.
- `redirect_pc`  in  32  target address, word aligned.
- `imem_en`  out  1  read strobe to instruction memory.
- `imem_addr`  out  32  read address.
- `imem_rdata`  in  32  read data, valid the cycle after an `imem_en` cycle.
- `IFID_pc`  out  32  PC of instruction in ID.
- `IFID_instr`  out  32  instruction in ID (0 = sll nop when invalid).
- `IFID_valid`  out  1  ID holds a real instruction.

## Operation
- Registers: `pc` (next sequential address), `f_valid`/`f_pc` (read issued last cycle), `hold_valid`/`hold_pc`/`hold_instr` (one-entry buffer), IF/ID register.
- `issue = redirect_valid | (PC_en & IFID_en)`; `imem_en = issue`; `imem_addr = redirect_valid ? redirect_pc : pc`.
- On issue: `pc <= imem_addr + 4` (mod 2^32, wraps 32'hFFFFFFFC -> 0); `f_valid <= 1`, `f_pc <= imem_addr`. No issue: `pc` held, `f_valid <= 0`.
- Arriving word: hold entry if `hold_valid`, else `{f_pc, imem_rdata}` if `f_valid`, else none.
- `IFID_en=1`: IF/ID loads arriving word (`IFID_valid=1`) or a bubble (`IFID_valid=0`, `IFID_instr=0`, `IFID_pc` unchanged); hold entry consumed.
- `IFID_en=0`: IF/ID unchanged; a memory word arriving with hold empty is captured into hold.
- Redirect (no macro): arriving word is the fall-through after the branch and is squashed -> IF/ID loads a bubble regardless of `IFID_en`; hold cleared; target issued the same cycle.
- `PC_en=1, IFID_en=0` is treated as a stall (no issue). `redirect_valid` with `IFID_en=0` is an ID protocol error; the block still applies the redirect.

## Timing
- Reset (async, immediate): `pc=RESET_PC`, `f_valid=0`, `hold_valid=0`, `IFID_pc=0`, `IFID_instr=0`, `IFID_valid=0`; `imem_en` follows from inputs.
- First cycle after reset release issues `RESET_PC`; instruction is in IF/ID one cycle later (fetch-to-ID latency 2 edges).
- Stall of N cycles: no issue and exactly one word captured into hold; on release the held word enters IF/ID on the first edge while `pc` is issued in the same cycle -> no lost or duplicated instruction.
- Reset mid-stall or mid-redirect discards hold and the in-flight read.
- Redirect penalty: one bubble without macro, zero with macro.

## Configuration
- `BRANCH_DELAY_SLOT_EN` defined: MIPS delay-slot semantics; on redirect the arriving word (delay slot) enters IF/ID normally (or is captured into hold if `IFID_en=0`); only the redirect overrides `pc`.
- Undefined: arriving word on a redirect cycle is squashed as described above.

## Test plan
- Reset release, `PC_en=IFID_en=1`, memory returns addr as data -> `imem_addr` 0xBFC00000, 0xBFC00004, ...; `IFID_pc`=0xBFC00000 with `IFID_valid=1` on 2nd edge.
- Stall 3 cycles with word 0xBFC00008 in flight -> `imem_en=0` for 3 cycles, IF/ID frozen; on release IF/ID=0xBFC00008 then 0xBFC0000C, no gaps or repeats.
- Redirect to 0x80000100 while IF/ID holds branch at 0xBFC00010 (no macro) -> IF/ID bubble for one cycle, then `IFID_pc`=0x80000100.
- Same with `BRANCH_DELAY_SLOT_EN` -> IF/ID = 0xBFC00014 then 0x80000100, no bubble.
- Redirect to 0xFFFFFFFC then run -> `imem_addr` 0xFFFFFFFC, 0x00000000.
- Assert `rst` during stall with hold full -> all outputs at reset values immediately; refetch from 0xBFC00000 after release.
